// File: rtl/skolem_chk_pkg.sv
// rtl/skolem_chk_pkg.sv - shared state encoding and limits for the Skolem sweep checker
package skolem_chk_pkg;

    localparam int SK_LAT_MAX = 3;
    localparam int LAT_W      = $clog2(SK_LAT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SAMPLE,
        SEARCH,
        JUDGE,
        DONE
    } state_t;

endpackage

// File: rtl/bvslt_neg_eval.sv
// rtl/bvslt_neg_eval.sv - combinational phi(x,t) = bvslt(bvneg(x), t) evaluator
module bvslt_neg_eval #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] t,
    output logic         sat
);

    logic [W-1:0] neg;

    // Modular negation: INT_MIN maps back onto itself
    assign neg = ~x + 1'b1;
    assign sat = $signed(neg) < $signed(t);

endmodule

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive sweep checker for a bvslt/bvneg Skolem block; SKOLEM_CHK_STOP_ON_CEX_EN ends the sweep at the first failure
module skolem_sweep_checker
    import skolem_chk_pkg::*;
#(
    parameter int W      = 2,
    parameter int SK_LAT = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     sk_t,
    input  logic [W-1:0]     sk_x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             cex_valid,
    output logic [W-1:0]     cex_t,
    output logic [W-1:0]     cex_x
);

    localparam logic [W-1:0]     ALL_ONES = '1;
    localparam logic [LAT_W-1:0] LAT_LAST = (SK_LAT == 0) ? '0 : LAT_W'(SK_LAT - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       t_q, t_d, xi_q, xi_d, x_s_q, x_s_d;
    logic [W-1:0]       cex_t_q, cex_t_d, cex_x_q, cex_x_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   fail_count_q, fail_count_d;
    logic               ok_q, ok_d, found_q, found_d;
    logic               pass_q, pass_d, cex_valid_q, cex_valid_d;
    logic               ok_now, found_now, t_fails, stop_on_fail;

    bvslt_neg_eval #(.W(W)) u_ok     (.x(sk_x), .t(t_q), .sat(ok_now));
    bvslt_neg_eval #(.W(W)) u_search (.x(xi_q), .t(t_q), .sat(found_now));

    // An unsatisfiable t accepts any witness, so only found && !ok counts
    assign t_fails = found_q && !ok_q;

`ifdef SKOLEM_CHK_STOP_ON_CEX_EN
    assign stop_on_fail = t_fails;
`else
    assign stop_on_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (SK_LAT == 0) ? SAMPLE : WAIT;
            WAIT:    if (lat_q == LAT_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = SEARCH;
            SEARCH:  if (found_now || xi_q == ALL_ONES) state_d = JUDGE;
            JUDGE: begin
                if (t_q == ALL_ONES || stop_on_fail) state_d = DONE;
                else state_d = (SK_LAT == 0) ? SAMPLE : WAIT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == WAIT) || (state_q == SAMPLE) ||
               (state_q == SEARCH) || (state_q == JUDGE);
        done = (state_q == DONE);
    end

    always_comb begin
        t_d          = t_q;
        xi_d         = xi_q;
        x_s_d        = x_s_q;
        lat_d        = lat_q;
        ok_d         = ok_q;
        found_d      = found_q;
        fail_count_d = fail_count_q;
        pass_d       = pass_q;
        cex_valid_d  = cex_valid_q;
        cex_t_d      = cex_t_q;
        cex_x_d      = cex_x_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    t_d          = '0;
                    lat_d        = '0;
                    fail_count_d = '0;
                    pass_d       = 1'b0;
                    cex_valid_d  = 1'b0;
                    cex_t_d      = '0;
                    cex_x_d      = '0;
                end
            end
            WAIT:   lat_d = lat_q + 1'b1;
            SAMPLE: begin
                x_s_d   = sk_x;
                ok_d    = ok_now;
                xi_d    = '0;
                found_d = 1'b0;
            end
            SEARCH: begin
                found_d = found_now;
                if (!found_now) xi_d = xi_q + 1'b1;
            end
            JUDGE: begin
                lat_d = '0;
                if (t_fails) begin
                    if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
                    if (!cex_valid_q) begin
                        cex_valid_d = 1'b1;
                        cex_t_d     = t_q;
                        cex_x_d     = x_s_q;
                    end
                end
                if (state_d == DONE) pass_d = (fail_count_d == '0);
                else t_d = t_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q          <= '0;
            xi_q         <= '0;
            x_s_q        <= '0;
            lat_q        <= '0;
            ok_q         <= 1'b0;
            found_q      <= 1'b0;
            fail_count_q <= '0;
            pass_q       <= 1'b0;
            cex_valid_q  <= 1'b0;
            cex_t_q      <= '0;
            cex_x_q      <= '0;
        end else begin
            t_q          <= t_d;
            xi_q         <= xi_d;
            x_s_q        <= x_s_d;
            lat_q        <= lat_d;
            ok_q         <= ok_d;
            found_q      <= found_d;
            fail_count_q <= fail_count_d;
            pass_q       <= pass_d;
            cex_valid_q  <= cex_valid_d;
            cex_t_q      <= cex_t_d;
            cex_x_q      <= cex_x_d;
        end
    end

    assign sk_t       = t_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign cex_valid  = cex_valid_q;
    assign cex_t      = cex_t_q;
    assign cex_x      = cex_x_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - self-checking bench for skolem_sweep_checker (W=2, SK_LAT 0 and 2)
module tb_skolem_sweep_checker;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, start0, start1;
    logic [1:0] sk_x0, sk_x1, p1;
    logic [1:0] sk_t0, sk_t1, cex_t0, cex_t1, cex_x0, cex_x1;
    logic       busy0, busy1, done0, done1, pass0, pass1, cv0, cv1;
    logic [7:0] fc0, fc1;

    typedef struct packed {
        logic       busy;
        logic [1:0] skt;
        logic       done;
    } exp_t;

    exp_t q0[$], q1[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   done0_cnt = 0;
    int   done1_cnt = 0;

    always #5 clk = ~clk;

    skolem_sweep_checker #(.W(2), .SK_LAT(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sk_t(sk_t0), .sk_x(sk_x0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
        .cex_valid(cv0), .cex_t(cex_t0), .cex_x(cex_x0)
    );

    skolem_sweep_checker #(.W(2), .SK_LAT(2), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sk_t(sk_t1), .sk_x(sk_x1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
        .cex_valid(cv1), .cex_t(cex_t1), .cex_x(cex_x1)
    );

    function automatic int sgn(int v);
        return (v >= N / 2) ? v - N : v;
    endfunction

    function automatic bit phi_m(int x, int t);
        return sgn((N - x) % N) < sgn(t);
    endfunction

    function automatic int first_sat(int t);
        for (int x = 0; x < N; x++) if (phi_m(x, t)) return x;
        return -1;
    endfunction

    function automatic int good_x(int t);
        int f;
        f = first_sat(t);
        return (f < 0) ? 0 : f;
    endfunction

    // Registered two-stage Skolem block returning a correct witness
    always @(posedge clk) begin
        p1    <= 2'(good_x(int'(sk_t1)));
        sk_x1 <= p1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0_busy", int'(busy0), int'(e.busy));
            chk("d0_sk_t", int'(sk_t0), int'(e.skt));
            chk("d0_done", int'(done0), int'(e.done));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1_busy", int'(busy1), int'(e.busy));
            chk("d1_sk_t", int'(sk_t1), int'(e.skt));
            chk("d1_done", int'(done1), int'(e.done));
        end
    end

    task automatic snap(input int d, output int b, output int dn, output int ps, output int fc,
                        output int cv, output int ct, output int cx, output int st);
        if (d == 0) begin
            b = busy0; dn = done0; ps = pass0; fc = fc0; cv = cv0; ct = cex_t0; cx = cex_x0; st = sk_t0;
        end else begin
            b = busy1; dn = done1; ps = pass1; fc = fc1; cv = cv1; ct = cex_t1; cx = cex_x1; st = sk_t1;
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v;
        else start1 = v;
    endtask

    // Per-t cycle budget and verdicts derived straight from the formula
    task automatic build(input int d, input int lat, input bit use_good, input int cx,
                         output int e_fc, output int e_cv, output int e_ct, output int e_cx,
                         output int e_pass, output int e_cycles);
        exp_t e;
        int   last_t;
        e_fc = 0; e_cv = 0; e_ct = 0; e_cx = 0; e_cycles = 0; last_t = 0;
        for (int t = 0; t < N; t++) begin
            int  f, k, x;
            bit  fails;
            f     = first_sat(t);
            k     = (f < 0) ? N : f + 1;
            x     = use_good ? good_x(t) : cx;
            fails = (f >= 0) && !phi_m(x, t);
            last_t = t;
            for (int c = 0; c < lat + 2 + k; c++) begin
                e = '{busy: 1'b1, skt: 2'(t), done: 1'b0};
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            e_cycles += lat + 2 + k;
            if (fails) begin
                if (e_cv == 0) begin
                    e_cv = 1; e_ct = t; e_cx = x;
                end
                e_fc++;
`ifdef SKOLEM_CHK_STOP_ON_CEX_EN
                break;
`endif
            end
        end
        e = '{busy: 1'b0, skt: 2'(last_t), done: 1'b1};
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        e_cycles += 1;
        e_pass = (e_fc == 0) ? 1 : 0;
    endtask

    task automatic run_sweep(input int d, input int lat, input bit use_good, input int cx,
                             input int lit_cycles, input bit poke);
        int e_fc, e_cv, e_ct, e_cx, e_pass, e_cycles, n;
        int b, dn, ps, fc, cv, ct, cxx, st;
        bit seen;
        if (d == 0) sk_x0 = 2'(cx);
        @(posedge clk); #1;
        done0_cnt = 0; done1_cnt = 0;
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
        build(d, lat, use_good, cx, e_fc, e_cv, e_ct, e_cx, e_pass, e_cycles);
        seen = 0; n = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 3) set_start(d, 1'b1);
            if (poke && i == 4) set_start(d, 1'b0);
            snap(d, b, dn, ps, fc, cv, ct, cxx, st);
            if (dn != 0) begin
                seen = 1; n = i;
            end
        end
        chk("done_seen", int'(seen), 1);
        chk("cycles_model", n, e_cycles);
        chk("cycles_literal", n, lit_cycles);
        chk("pass", ps, e_pass);
        chk("fail_count", fc, e_fc);
        chk("cex_valid", cv, e_cv);
        chk("cex_t", ct, e_ct);
        chk("cex_x", cxx, e_cx);
        if (poke) set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        for (int i = 0; i < 4; i++) begin
            snap(d, b, dn, ps, fc, cv, ct, cxx, st);
            chk("idle_busy", b, 0);
            chk("idle_done", dn, 0);
            chk("hold_pass", ps, e_pass);
            chk("hold_fail_count", fc, e_fc);
            @(negedge clk);
        end
        chk("done_pulses", (d == 0) ? done0_cnt : done1_cnt, 1);
        chk("queue_drained", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        int b, dn, ps, fc, cv, ct, cxx, st;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sk_x0 = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            snap(d, b, dn, ps, fc, cv, ct, cxx, st);
            chk("rst_busy", b, 0);
            chk("rst_done", dn, 0);
            chk("rst_pass", ps, 0);
            chk("rst_fail_count", fc, 0);
            chk("rst_cex_valid", cv, 0);
            chk("rst_sk_t", st, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // INT_MIN witness always works: 4+3+6+5 cycles plus DONE
        run_sweep(0, 0, 1'b0, 2, 19, 1'b0);
`ifdef SKOLEM_CHK_STOP_ON_CEX_EN
        run_sweep(0, 0, 1'b0, 0, 5, 1'b0);
        chk("lit_fc_stop", int'(fc0), 1);
`else
        run_sweep(0, 0, 1'b0, 0, 19, 1'b0);
        chk("lit_fc_zero_witness", int'(fc0), 2);
`endif
        chk("lit_cex_t", int'(cex_t0), 0);
        chk("lit_pass_zero_witness", int'(pass0), 0);

        run_sweep(1, 2, 1'b1, 0, 27, 1'b0);
        chk("lit_pass_lat2", int'(pass1), 1);

        // Reset lands in cycle 6 after start: SEARCH of t=01
        sk_x0 = 2'b10;
        @(posedge clk); #1;
        done0_cnt = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_sk_t", int'(sk_t0), 1);
        chk("mid_busy", int'(busy0), 1);
        rst_n = 1'b0;
        q0.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_sk_t", int'(sk_t0), 0);
        chk("abort_done", int'(done0), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done0_cnt, 0);

        run_sweep(0, 0, 1'b0, 2, 19, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_checker.md
Name: skolem_sweep_checker

Overview:
- Sequential exhaustive checker that sits directly downstream of a generated Skolem-function netlist for the bvslt/bvneg invertibility condition.
- It drives every value of the free vector t into the Skolem block and samples the witness x that the block returns.
- For each t it decides whether a valid witness exists at all (exists x: bvslt(bvneg(x), t)), then checks that the returned witness satisfies the formula.
- It reports pass/fail, a saturating failure count and the first counterexample.

Parameters:
- W, 2, bit-vector width of t and x (1..8).
- SK_LAT, 0, cycles between driving sk_t and sampling sk_x (0..3); covers registered Skolem wrappers.
- CNT_W, 8, width of fail_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy=1.
- sk_t  out  W  t value presented to the Skolem block.
- sk_x  in  W  witness returned by the Skolem block.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep ends.
- pass  out  1  valid from done until the next start; 1 when fail_count==0.
- fail_count  out  CNT_W  number of failing t values, saturating at all-ones.
- cex_valid  out  1  set when the first failure is recorded.
- cex_t  out  W  t of the first failure.
- cex_x  out  W  sk_x returned for that t.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE and all outputs 0 (sk_t=0, busy=0, done=0, pass=0, fail_count=0, cex_*=0). Reset mid-sweep aborts immediately with no done pulse.
- Formula phi(x,t) = (-x mod 2^W) <s t, both operands two's complement. bvneg(INT_MIN)=INT_MIN (no widening).
- IDLE: on start, clear fail_count, cex_valid and pass; set t=0, busy=1; go to WAIT.
- WAIT: hold sk_t=t for SK_LAT cycles (0 means skip), then go to SAMPLE.
- SAMPLE: one cycle. Register x_s=sk_x and ok=phi(x_s,t). Set xi=0, found=0. Go to SEARCH.
- SEARCH: one xi per cycle. If phi(xi,t), set found=1 and exit early. Otherwise increment xi. Leave SEARCH when found, or after xi=2^W-1 has been evaluated. Go to JUDGE.
- JUDGE: the t value fails iff found && !ok.
  - On failure: increment fail_count with saturation.
  - On the first failure: latch cex_t=t and cex_x=x_s, and set cex_valid=1.
  - If t==2^W-1, go to DONE. Otherwise t=t+1 (unsigned enumeration order 0..2^W-1) and go to WAIT.
- DONE: one cycle with done=1, pass=(fail_count==0), busy=0; return to IDLE.
- Output holding: pass, fail_count and cex_* hold until the next accepted start.
- If t is unsatisfiable (found=0), any witness is acceptable and the t value never fails.
- start asserted in the same cycle as done is ignored; start is accepted only in IDLE.
- sk_t changes only on the JUDGE->WAIT transition. The Skolem block sees a stable input for SK_LAT+1 cycles before sampling.
- Per-t latency is SK_LAT + 1 (SAMPLE) + k (SEARCH, 1..2^W) + 1 (JUDGE) cycles.

Optional Feature:
- Macro: SKOLEM_CHK_STOP_ON_CEX_EN.
- Defined: the first failure ends the sweep, with JUDGE going straight to DONE. fail_count is then 1 and pass=0.
- Undefined: the sweep always covers all 2^W t values, as described above.

Decomposition:
- Package skolem_chk_pkg holds the state enum (IDLE, WAIT, SAMPLE, SEARCH, JUDGE, DONE) and the SK_LAT_MAX=3 constant.
- Sub-module bvslt_neg_eval: a combinational evaluator of phi, parameterised by W.
  - Ports: x, t, sat.
  - Two instances: one for the sampled witness (ok), one for the search (found).

Test Plan (W=2, SK_LAT=0 unless stated):
- sk_x tied to 2'b10 (INT_MIN) -> done after the sweep, pass=1, fail_count=0, cex_valid=0.
- sk_x tied to 2'b00 -> failures at t=00 and t=11; fail_count=2, cex_t=00, cex_x=00, pass=0. t=10 is unsatisfiable and is not counted.
- Same stimulus with SKOLEM_CHK_STOP_ON_CEX_EN defined -> done after t=00 is judged; fail_count=1, cex_t=00, sk_t never leaves 00.
- SK_LAT=2 with a 2-stage registered Skolem block that outputs the correct witness -> pass=1. sk_t is held for 3 cycles per t before SAMPLE. Checker checks this hold timing.
- rst_n=0 asserted during SEARCH of t=01 -> next cycle busy=0, sk_t=00, no done pulse. A following start runs a full clean sweep.
- start pulsed while busy=1, and again in the done cycle -> both ignored; only one done pulse occurs and state returns to IDLE.
